// File: rtl/dm_rom_axi_rd.sv
// AXI4 read-only slave for the debug module program ROM.
// Streams bursts back-to-back by prefetching the next ROM word during each beat.
module dm_rom_axi_rd #(
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int ADDR_END   = (AXI_DATA_W == 64) ? 1 : 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [6:0]            araddr,
    input  logic [AXI_ID_W-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [AXI_ID_W-1:0]   rid,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic [4:ADDR_END]     rom_addr,
    input  logic [AXI_DATA_W-1:0] rom_rdata
);

    localparam int               IDX_W       = 5 - ADDR_END;
    localparam logic [2:0]       SIZE_MAX    = (AXI_DATA_W == 64) ? 3'd3 : 3'd2;
    localparam logic [1:0]       BURST_FIXED = 2'd0;
    localparam logic [1:0]       BURST_WRAP  = 2'd2;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [IDX_W-1:0] IDX_ONE     = 1;

    typedef enum logic {IDLE, DATA} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   nxt_idx;
    logic [IDX_W-1:0]   ar_idx;
    logic [IDX_W-1:0]   len_mask;
    logic [7:0]         cnt;
    logic [7:0]         len;
    logic [1:0]         burst;
    logic               err;
    logic               wrap_len_ok;
    logic               ar_err;
    logic               ar_hs;
    logic               r_hs;
    logic               unused_addr;

    assign ar_idx      = araddr[6:2+ADDR_END];
    assign unused_addr = ^araddr[1+ADDR_END:0];
    assign len_mask    = len[IDX_W-1:0];

    assign wrap_len_ok = (arlen == 8'd1) || (arlen == 8'd3) ||
                         (arlen == 8'd7) || (arlen == 8'd15);
    assign ar_err      = (arsize > SIZE_MAX) || (arburst == 2'd3) ||
                         ((arburst == BURST_WRAP) && !wrap_len_ok);

    // Erroneous bursts still walk the ROM, but always as INCR.
    always_comb begin
        nxt_idx = idx + IDX_ONE;
        if (!err) begin
            case (burst)
                BURST_FIXED: nxt_idx = idx;
                BURST_WRAP:  nxt_idx = (idx & ~len_mask) | ((idx + IDX_ONE) & len_mask);
                default:     nxt_idx = idx + IDX_ONE;
            endcase
        end
    end

    // While a beat is presented the ROM already looks up the following one.
    assign rom_addr = (state == IDLE) ? ar_idx : nxt_idx;
    assign arready  = (state == IDLE);
    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
            rresp  <= RESP_OKAY;
            idx    <= '0;
            cnt    <= '0;
            len    <= '0;
            burst  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        state  <= DATA;
                        rid    <= arid;
                        len    <= arlen;
                        burst  <= arburst;
                        err    <= ar_err;
                        idx    <= ar_idx;
                        cnt    <= '0;
                        rdata  <= rom_rdata;
                        rresp  <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid <= 1'b1;
                        rlast  <= (arlen == 8'd0);
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        if (rlast) begin
                            state  <= IDLE;
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                        end else begin
                            idx   <= nxt_idx;
                            cnt   <= cnt + 8'd1;
                            rdata <= rom_rdata;
                            rlast <= ((cnt + 8'd1) == len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_rom_axi_rd.sv
// Directed bench for dm_rom_axi_rd: 32-bit and 64-bit instances against a small ROM table.
module tb_dm_rom_axi_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arvalid, arvalid64;
    logic [6:0]  araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rready64;

    logic        arready, rvalid, rlast;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic [4:0]  rom_addr;
    logic [31:0] rom_rdata;

    logic        arready64, rvalid64, rlast64;
    logic [63:0] rdata64;
    logic [3:0]  rid64;
    logic [1:0]  rresp64;
    logic [4:1]  rom_addr64;
    logic [63:0] rom_rdata64;

    logic [31:0] rom [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_rdata   = rom[rom_addr];
    assign rom_rdata64 = {rom[{rom_addr64, 1'b1}], rom[{rom_addr64, 1'b0}]};

    dm_rom_axi_rd #(.AXI_DATA_W(32), .AXI_ID_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
        .rresp(rresp), .rlast(rlast),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata)
    );

    dm_rom_axi_rd #(.AXI_DATA_W(64), .AXI_ID_W(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .arvalid(arvalid64), .arready(arready64), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid64), .rready(rready64), .rdata(rdata64), .rid(rid64),
        .rresp(rresp64), .rlast(rlast64),
        .rom_addr(rom_addr64), .rom_rdata(rom_rdata64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one AR on the 32-bit (wide=0) or 64-bit (wide=1) instance; returns at the
    // negedge where the first beat is visible.
    task automatic send_ar(input logic [6:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id, input bit wide);
        chk(wide ? "arready64_pre" : "arready_pre", wide ? arready64 : arready, 1'b1);
        araddr  = a;
        arlen   = l;
        arsize  = s;
        arburst = b;
        arid    = id;
        if (wide) arvalid64 = 1'b1;
        else      arvalid   = 1'b1;
        @(negedge clk);
        arvalid   = 1'b0;
        arvalid64 = 1'b0;
    endtask

    // Check the beat currently presented on the 32-bit R channel, then drive rready for one cycle.
    task automatic beat(input string tag, input logic [31:0] d, input logic last,
                        input logic [1:0] resp, input logic rdy);
        chk({tag, "_rvalid"}, rvalid, 1'b1);
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rlast"}, rlast, last);
        chk({tag, "_rresp"}, rresp, resp);
        rready = rdy;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hA5A5_0000 | i;
        rom[0]  = 32'h00c0006f;
        rom[1]  = 32'h0600006f;
        rom[4]  = 32'h7b241073;
        rom[5]  = 32'hf1402473;
        rom[6]  = 32'h10802023;
        rom[7]  = 32'h40044403;
        rom[16] = 32'h7b202473;
        rom[17] = 32'h10002623;
        rom[18] = 32'h00100073;
        rom[19] = 32'hf1402473;

        rst_n = 1'b0;
        arvalid = 0; arvalid64 = 0; araddr = 0; arid = 0; arlen = 0;
        arsize = 0; arburst = 0; rready = 0; rready64 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast",  rlast,  1'b0);
        chk("rst_rdata",  rdata,  32'h0);
        chk("rst_rid",    rid,    4'h0);
        chk("rst_rresp",  rresp,  2'b00);
        chk("rst_rvalid64", rvalid64, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready_after_rst", arready, 1'b1);

        // 32-bit single read
        send_ar(7'h04, 8'd0, 3'd2, 2'd1, 4'h5, 1'b0);
        chk("single_rid", rid, 4'h5);
        chk("single_arready_busy", arready, 1'b0);
        beat("single", 32'h0600006f, 1'b1, 2'b00, 1'b1);
        chk("single_done_rvalid", rvalid, 1'b0);
        chk("single_idle_arready", arready, 1'b1);
        rready = 1'b0;

        // 32-bit INCR burst with backpressure 1,0,1,1,0,1
        send_ar(7'h10, 8'd3, 3'd2, 2'd1, 4'h9, 1'b0);
        beat("incr_b0",  32'h7b241073, 1'b0, 2'b00, 1'b1);
        beat("incr_b1",  32'hf1402473, 1'b0, 2'b00, 1'b0);
        beat("incr_b1h", 32'hf1402473, 1'b0, 2'b00, 1'b1);
        beat("incr_b2",  32'h10802023, 1'b0, 2'b00, 1'b1);
        beat("incr_b3",  32'h40044403, 1'b1, 2'b00, 1'b0);
        chk("incr_rid_held", rid, 4'h9);
        beat("incr_b3h", 32'h40044403, 1'b1, 2'b00, 1'b1);
        chk("incr_done_rvalid", rvalid, 1'b0);
        rready = 1'b0;

        // 32-bit WRAP burst: indices 18,19,16,17
        send_ar(7'h48, 8'd3, 3'd2, 2'd2, 4'hA, 1'b0);
        chk("wrap_prefetch_addr", rom_addr, 5'd19);
        beat("wrap_b0", 32'h00100073, 1'b0, 2'b00, 1'b1);
        chk("wrap_prefetch_addr2", rom_addr, 5'd16);
        beat("wrap_b1", 32'hf1402473, 1'b0, 2'b00, 1'b1);
        beat("wrap_b2", 32'h7b202473, 1'b0, 2'b00, 1'b1);
        chk("wrap_rid", rid, 4'hA);
        beat("wrap_b3", 32'h10002623, 1'b1, 2'b00, 1'b1);
        chk("wrap_done_rvalid", rvalid, 1'b0);
        rready = 1'b0;

        // INCR crossing the ROM end wraps silently to index 0
        send_ar(7'h7C, 8'd1, 3'd2, 2'd1, 4'h1, 1'b0);
        beat("incr_end_b0", 32'hA5A5001F, 1'b0, 2'b00, 1'b1);
        beat("incr_end_b1", 32'h00c0006f, 1'b1, 2'b00, 1'b1);
        rready = 1'b0;

        // FIXED burst repeats the same word
        send_ar(7'h04, 8'd2, 3'd2, 2'd0, 4'h2, 1'b0);
        beat("fixed_b0", 32'h0600006f, 1'b0, 2'b00, 1'b1);
        beat("fixed_b1", 32'h0600006f, 1'b0, 2'b00, 1'b1);
        beat("fixed_b2", 32'h0600006f, 1'b1, 2'b00, 1'b1);
        rready = 1'b0;

        // 64-bit single read
        send_ar(7'h00, 8'd0, 3'd3, 2'd1, 4'h7, 1'b1);
        chk("w64_rvalid", rvalid64, 1'b1);
        chk("w64_rdata",  rdata64,  64'h0600006f00c0006f);
        chk("w64_rresp",  rresp64,  2'b00);
        chk("w64_rlast",  rlast64,  1'b1);
        chk("w64_rid",    rid64,    4'h7);
        chk("w64_other_idle", rvalid, 1'b0);
        rready64 = 1'b1;
        @(negedge clk);
        chk("w64_done_rvalid", rvalid64, 1'b0);
        rready64 = 1'b0;

        // Oversized arsize on the 32-bit bus
        send_ar(7'h04, 8'd0, 3'd3, 2'd1, 4'h3, 1'b0);
        beat("err_size", 32'h0600006f, 1'b1, 2'b10, 1'b1);
        rready = 1'b0;

        // Reserved burst type: SLVERR on both beats, INCR addressing
        send_ar(7'h10, 8'd1, 3'd2, 2'd3, 4'h4, 1'b0);
        beat("err_burst_b0", 32'h7b241073, 1'b0, 2'b10, 1'b1);
        beat("err_burst_b1", 32'hf1402473, 1'b1, 2'b10, 1'b1);
        rready = 1'b0;

        // WRAP with illegal length falls back to INCR with SLVERR
        send_ar(7'h48, 8'd2, 3'd2, 2'd2, 4'h6, 1'b0);
        beat("err_wrap_b0", 32'h00100073, 1'b0, 2'b10, 1'b1);
        beat("err_wrap_b1", 32'hf1402473, 1'b0, 2'b10, 1'b1);
        beat("err_wrap_b2", 32'hA5A50014, 1'b1, 2'b10, 1'b1);
        rready = 1'b0;

        // Asynchronous reset in the middle of an 8-beat burst
        send_ar(7'h00, 8'd7, 3'd2, 2'd1, 4'hC, 1'b0);
        beat("rst_mid_b0", 32'h00c0006f, 1'b0, 2'b00, 1'b1);
        beat("rst_mid_b1", 32'h0600006f, 1'b0, 2'b00, 1'b1);
        chk("rst_mid_b2_rdata", rdata, 32'hA5A50002);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", rvalid, 1'b0);
        chk("rst_mid_rlast",  rlast,  1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        rready = 1'b0;
        chk("rst_mid_arready", arready, 1'b1);
        @(negedge clk);
        chk("rst_mid_no_beat", rvalid, 1'b0);
        send_ar(7'h00, 8'd0, 3'd2, 2'd1, 4'hD, 1'b0);
        beat("post_rst", 32'h00c0006f, 1'b1, 2'b00, 1'b1);
        chk("post_rst_done", rvalid, 1'b0);
        rready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_rom_axi_rd.md
# dm_rom_axi_rd

AXI4 read-only slave front end for the debug module's program ROM. It accepts AR requests from the debug-memory address decoder, drives the ROM word index to the combinational debug ROM, and returns bursts on the R channel with zero bubbles between beats. It sits directly upstream of the ROM and owns all AXI read handshaking, burst sequencing and error responses for the ROM window; writes are handled elsewhere.

## Interface
- AXI_DATA_W, 32: bus width; only 32 and 64 are legal.
- AXI_ID_W, 4: ID width.
- ADDR_END, (AXI_DATA_W==64)?1:0: LSB of the ROM word index.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- arvalid / arready  input / output  1  AR handshake.
- araddr  input  7  byte offset inside the 128-byte ROM window; upper bits are stripped by the decoder.
- arid  input  AXI_ID_W  request ID.
- arlen  input  8  beats minus 1.
- arsize  input  3  beat size.
- arburst  input  2  burst type.
- rvalid / rready  output / input  1  R handshake.
- rdata  output  AXI_DATA_W  read data.
- rid  output  AXI_ID_W  echoes arid.
- rresp  output  2  OKAY = 2'b00, SLVERR = 2'b10.
- rlast  output  1  last beat.
- rom_addr  output  [4:ADDR_END]  ROM word index.
- rom_rdata  input  AXI_DATA_W  combinational ROM data for rom_addr.

## Operation
- The index width is IDX_W = 5-ADDR_END. There are 32 beats for a 32-bit bus and 16 beats for a 64-bit bus. The beat index is araddr[6:2+ADDR_END].
- FSM states are IDLE and DATA.
  - arready = (state==IDLE).
  - IDLE -> DATA on an AR handshake.
  - DATA -> IDLE on an R handshake with rlast=1.
- Actions on the AR handshake:
  - Latch arid, arlen and arburst, plus an error flag.
  - Load idx with the beat index.
  - Load cnt = 0.
  - Load rdata with rom_rdata sampled at the request index.
  - Set rvalid = 1 and rlast = (arlen==0).
- rom_addr mux:
  - In IDLE, rom_addr = the araddr beat index.
  - In DATA, rom_addr = nxt_idx, the index of the following beat. This prefetches data so the next beat loads on the same edge as the handshake.
- Actions on an R handshake that is not the last beat:
  - idx <= nxt_idx.
  - cnt <= cnt+1.
  - rdata <= rom_rdata.
  - rlast <= (cnt+1 == len).
  - rvalid stays 1.
- nxt_idx by burst type:
  - FIXED (0): nxt_idx = idx.
  - INCR (1): nxt_idx = idx+1, modulo 2^IDX_W. Wrap-around at the ROM end is silent.
  - WRAP (2): nxt_idx = (idx & ~len) | ((idx+1) & len). This is legal only when len ∈ {1,3,7,15}.
- Error flag: set if any of the following holds. When set, rresp = SLVERR on every beat of the burst, rdata still carries ROM data, and addressing falls back to INCR.
  - arsize > log2(AXI_DATA_W/8).
  - arburst == 3.
  - WRAP with an illegal len.
- Otherwise rresp = OKAY. rid is held for the whole burst.
- rvalid is never deasserted mid-burst. rdata, rlast, rresp and rid stay stable while rvalid=1 and rready=0.

## Timing
- Reset values: rvalid=0, rlast=0, rdata=0, rid=0, rresp=0, state=IDLE. arready=1 once rst_n is high.
- Latency: rvalid rises on the edge that completes the AR handshake, so the first beat is visible in the next cycle.
- Throughput:
  - One beat per cycle while rready=1.
  - One idle cycle (arready=1) is required after rlast before the next AR can be accepted. A new AR is never accepted in the cycle of the last R handshake.
- A 256-beat INCR burst wraps the index repeatedly; cnt is 8 bits, so rlast is exact.
- Asynchronous reset mid-burst: rvalid and rlast drop immediately, the FSM returns to IDLE, and the remaining beats are discarded.
- The ROM path is purely combinational: rom_addr to rom_rdata settles within the cycle, and there are no ROM wait states.

## Test plan
- 32-bit single read: araddr=0x04, arlen=0, INCR. Required response: the next cycle shows rvalid=1, rdata=0x0600006f, rlast=1, rresp=0, and the arid is echoed.
- 32-bit INCR burst: araddr=0x10, arlen=3, with rready toggling 1,0,1,1,0,1. Required response:
  - Beats are 0x7b241073, 0xf1402473, 0x10802023, 0x40044403.
  - rlast is set only on the 4th beat.
  - Data is held stable while rready=0.
- 32-bit WRAP burst: araddr=0x48, arlen=3, arburst=2. Required response:
  - The index sequence is 18, 19, 16, 17.
  - The data is 0x00100073, 0xf1402473, 0x7b202473, 0x10002623.
- 64-bit single read: araddr=0x00, arsize=3. Required response: rdata=0x0600006f00c0006f, OKAY.
- Errors on a 32-bit bus, each a separate request:
  - arsize=3: required response is rresp=2'b10 with ROM data still returned.
  - arburst=3 with arlen=1: required response is 2 beats, both SLVERR, addressed as INCR.
- Reset mid-burst: assert rst_n=0 asynchronously after beat 2 of an arlen=7 burst. Required response:
  - rvalid=0 at once.
  - After release, arready=1, and a new read at 0x00 returns 0x00c0006f.
